// File: rtl/aes_run_sequencer.sv
// Run sequencer for the iterative AES-128 core used in the power-analysis demo.
// Issues chained encryptions separated by a quiet gap, drives the scope trigger and run status.
module aes_run_sequencer #(
  parameter logic [127:0] PT_SEED        = 128'h00112233445566778899aabbccddeeff,
  parameter int unsigned  GAP_CYCLES     = 64,
  parameter int unsigned  TIMEOUT_CYCLES = 256,
  parameter int unsigned  RUN_LIMIT      = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         enable_i,
  output logic         aes_start_o,
  output logic [127:0] aes_pt_o,
  input  logic         aes_done_i,
  input  logic [127:0] aes_ct_i,
  output logic         trigger_o,
  output logic [15:0]  run_count_o,
  output logic         heartbeat_o,
  output logic         busy_o,
  output logic         halted_o,
  output logic         error_o
);

  localparam int unsigned    TMAX     = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned    TW       = $clog2(TMAX) + 1;
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [15:0]    LIMIT    = 16'(RUN_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4,
    S_HALT    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [127:0]   pt_q, pt_d;
  logic [15:0]    count_q, count_d;
  logic           hb_q, hb_d;
  logic           err_q, err_d;
  logic           start_q, trig_q, busy_q, halt_q;

  // Next-state and datapath updates; aes_done is only honoured in WAIT.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pt_d    = pt_q;
    count_d = count_q;
    hb_d    = hb_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_START;
        else          state_d = S_IDLE;
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (aes_done_i) begin
          state_d = S_CAPTURE;
          pt_d    = aes_ct_i;
          hb_d    = ~hb_q;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          else                     count_d = count_q;
        end else if (timer_q == TO_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CAPTURE: begin
        timer_d = '0;
        if ((LIMIT != 16'd0) && (count_q == LIMIT)) state_d = S_HALT;
        else                                        state_d = S_GAP;
      end
      S_GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == GAP_LAST) begin
          if (enable_i) state_d = S_START;
          else          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_HALT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          count_d = 16'd0;
        end else begin
          state_d = S_HALT;
        end
      end
      S_ERROR: begin
        err_d = 1'b1;
        if (!enable_i) state_d = S_IDLE;
        else           state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      pt_q    <= PT_SEED;
      count_q <= 16'd0;
      hb_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pt_q    <= pt_d;
      count_q <= count_d;
      hb_q    <= hb_d;
      err_q   <= err_d;
      start_q <= (state_d == S_START);
      trig_q  <= (state_d == S_START) || (state_d == S_WAIT);
      busy_q  <= (state_d == S_START) || (state_d == S_WAIT) ||
                 (state_d == S_CAPTURE) || (state_d == S_GAP);
      halt_q  <= (state_d == S_HALT);
    end
  end

  assign aes_start_o = start_q;
  assign aes_pt_o    = pt_q;
  assign trigger_o   = trig_q;
  assign run_count_o = count_q;
  assign heartbeat_o = hb_q;
  assign busy_o      = busy_q;
  assign halted_o    = halt_q;
  assign error_o     = err_q;

endmodule
